uart_rx_fifo: RTL

Receive-side byte buffer sitting directly downstream of uart_rx. It captures every byte or BREAK event uart_rx reports and queues it. It presents the queue to the consumer (CPU bridge or protocol parser) through a first-word-fall-through valid/ready interface. It reports fill level, an almost-full watermark and a sticky overflow flag, so slow consumers never silently lose data.

---
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_fifo.sv | 92 +++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between uart_rx, the receive FIFO and its consumer.
// The FIFO drives its side through the slave modport.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              uart_rx_valid;
    logic [7:0]        uart_rx_data;
    logic              uart_rx_break;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic              rd_break;
    logic              rd_ready;
    logic [ADDR_W:0]   count;
    logic              almost_full;
    logic              full;
    logic              overflow;
    logic              ovf_clear;

    modport slave (
        input  uart_rx_valid, uart_rx_data, uart_rx_break, rd_ready, ovf_clear,
        output rd_valid, rd_data, rd_break, count, almost_full, full, overflow
    );

    modport master (
        output uart_rx_valid, uart_rx_data, uart_rx_break, rd_ready, ovf_clear,
        input  rd_valid, rd_data, rd_break, count, almost_full, full, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte/BREAK queue behind uart_rx, with fill level,
// almost-full watermark and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic           clk,
    input  logic           resetn,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned ENTRY_W = 9;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wptr;
    logic [ADDR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

    // BREAK takes precedence over a coincident data byte.
    always_comb begin
        w_push  = bus.uart_rx_valid | bus.uart_rx_break;
        w_entry = bus.uart_rx_break ? {1'b1, 8'h00} : {1'b0, bus.uart_rx_data};
        w_full  = (r_count == CNT_W'(DEPTH));
        w_empty = (r_count == '0);
        w_pop   = ~w_empty & bus.rd_ready;
        w_wr    = w_push & (~w_full | w_pop);
        w_drop  = w_push & w_full & ~w_pop;
        w_head  = r_mem[r_rptr];
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.rd_valid    = ~w_empty;
    assign bus.rd_data     = w_empty ? 8'h00 : w_head[7:0];
    assign bus.rd_break    = ~w_empty & w_head[8];
    assign bus.count       = r_count;
    assign bus.almost_full = (r_count >= CNT_W'(AF_LEVEL));
    assign bus.full        = w_full;
    assign bus.overflow    = r_overflow;
endmodule
